// File: rtl/text_screen_buffer_pkg.sv
// Shared definitions for the character display path.
// Holds the control-code values recognised by the screen buffer, the
// controller state enumeration and a printable-range helper.
package text_screen_buffer_pkg;

    localparam logic [7:0] CHAR_BS       = 8'h08;
    localparam logic [7:0] CHAR_LF       = 8'h0A;
    localparam logic [7:0] CHAR_FF       = 8'h0C;
    localparam logic [7:0] CHAR_CR       = 8'h0D;
    localparam logic [7:0] CHAR_DEL      = 8'h7F;
    localparam logic [7:0] CHAR_SPACE    = 8'h20;
    localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
    localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    // True for codes that are stored as glyphs rather than interpreted.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CHAR_PRINT_LO) && (c <= CHAR_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_screen_buffer_rx_byte_capture.sv
// rx_byte_capture: turns the UART byte-valid level into single accepted
// bytes and parks each one in a one-entry pending slot until the screen
// controller consumes it.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   byte_ready     - byte-valid level; a 0->1 transition flags a new byte
//   data           - received byte, sampled on the accepting edge
//   consume        - controller takes the pending byte this cycle
//   pending_valid  - slot holds a byte
//   pending_data   - the held byte
//   overflow       - one-cycle pulse when an arriving byte is dropped
module rx_byte_capture
    import text_screen_buffer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_ready,
    input  logic [7:0] data,
    input  logic       consume,
    output logic       pending_valid,
    output logic [7:0] pending_data,
    output logic       overflow
);

    logic       ready_prev_r;
    logic       valid_r;
    logic [7:0] data_r;
    logic       overflow_r;
    logic       rise_s;

    // Previous level resets high so a level already asserted through reset
    // never looks like a fresh byte.
    assign rise_s = byte_ready & ~ready_prev_r;

    // Edge history, pending slot and drop pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_prev_r <= 1'b1;
            valid_r      <= 1'b0;
            data_r       <= 8'h00;
            overflow_r   <= 1'b0;
        end else begin
            ready_prev_r <= byte_ready;
            // A byte arriving while the slot is occupied is lost, even if
            // the occupant is being consumed on the same edge.
            overflow_r   <= rise_s & valid_r;
            if (rise_s && !valid_r) begin
                valid_r <= 1'b1;
                data_r  <= data;
            end else if (consume) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign pending_valid = valid_r;
    assign pending_data  = data_r;
    assign overflow      = overflow_r;

endmodule

// File: rtl/text_screen_buffer.sv
// text_screen_buffer: character-cell screen memory fed by a UART byte
// stream. Printable bytes are stored at the cursor; backspace, carriage
// return, line feed and form feed move the cursor or clear the screen.
// Overflowing the last row either scrolls the screen up one row
// (WRAP_MODE=0) or wraps the cursor back to row 0 (WRAP_MODE=1).
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   byteReady, data       - UART byte-valid level and received byte
//   outRow, outCol        - display read address
//   outByte               - registered character at (outRow,outCol)
//   cursorRow, cursorCol  - next write position
//   busy                  - high while clearing or scrolling
//   overflow              - one-cycle pulse when a byte is dropped
module text_screen_buffer
    import text_screen_buffer_pkg::*;
#(
    parameter  int ROWS      = 4,
    parameter  int COLS      = 16,
    parameter  int WRAP_MODE = 0,
    localparam int RW        = $clog2(ROWS),
    localparam int CW        = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          byteReady,
    input  logic [7:0]    data,
    input  logic [RW-1:0] outRow,
    input  logic [CW-1:0] outCol,
    output logic [7:0]    outByte,
    output logic [RW-1:0] cursorRow,
    output logic [CW-1:0] cursorCol,
    output logic          busy,
    output logic          overflow
);

    // COLS is a power of two, so {row,col} is the linear cell index
    // row*COLS+col and AW bits cover every cell exactly.
    localparam int            AW          = RW + CW;
    localparam int            NCELL       = ROWS * COLS;
    localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL    = CW'(COLS - 1);
    localparam logic [AW-1:0] LAST_CELL   = AW'(NCELL - 1);
    localparam logic [AW-1:0] SHIFT_CELLS = AW'(NCELL - COLS);
    localparam logic [AW-1:0] ROW_STRIDE  = AW'(COLS);

    logic [7:0]    mem_r [NCELL];
    state_t        state_r;
    state_t        state_s;
    logic [AW-1:0] sweep_r;
    logic [AW-1:0] sweep_s;
    logic [RW-1:0] row_r;
    logic [RW-1:0] row_s;
    logic [CW-1:0] col_r;
    logic [CW-1:0] col_s;
    logic          busy_r;
    logic [7:0]    out_byte_r;

    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [7:0]    wr_data_s;
    logic          consume_s;
    logic          newline_s;
    logic [AW-1:0] src_addr_s;

    logic          pending_valid_s;
    logic [7:0]    pending_data_s;

    rx_byte_capture u_capture (
        .clk           (clk),
        .rst_n         (rst_n),
        .byte_ready    (byteReady),
        .data          (data),
        .consume       (consume_s),
        .pending_valid (pending_valid_s),
        .pending_data  (pending_data_s),
        .overflow      (overflow)
    );

    // During a scroll the cell one row below the sweep position is the
    // copy source; it is only used while the sweep is above the last row.
    assign src_addr_s = sweep_r + ROW_STRIDE;

    // Next-state, cursor update and single storage write port.
    always_comb begin
        state_s   = state_r;
        sweep_s   = sweep_r;
        row_s     = row_r;
        col_s     = col_r;
        wr_en_s   = 1'b0;
        wr_addr_s = {row_r, col_r};
        wr_data_s = CHAR_SPACE;
        consume_s = 1'b0;
        newline_s = 1'b0;

        case (state_r)
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = sweep_r;
                wr_data_s = CHAR_SPACE;
                if (sweep_r == LAST_CELL) begin
                    state_s = ST_IDLE;
                    sweep_s = '0;
                end else begin
                    sweep_s = sweep_r + 1'b1;
                end
            end
            ST_SCROLL: begin
                wr_en_s   = 1'b1;
                wr_addr_s = sweep_r;
                if (sweep_r < SHIFT_CELLS) begin
                    wr_data_s = mem_r[src_addr_s];
                end else begin
                    wr_data_s = CHAR_SPACE;
                end
                if (sweep_r == LAST_CELL) begin
                    state_s = ST_IDLE;
                    sweep_s = '0;
                end else begin
                    sweep_s = sweep_r + 1'b1;
                end
            end
            ST_IDLE: begin
                if (pending_valid_s) begin
                    consume_s = 1'b1;
                    if (is_printable(pending_data_s)) begin
                        wr_en_s   = 1'b1;
                        wr_data_s = pending_data_s;
                        if (col_r == LAST_COL) begin
                            newline_s = 1'b1;
                        end else begin
                            col_s = col_r + 1'b1;
                        end
                    end else begin
                        case (pending_data_s)
                            CHAR_BS, CHAR_DEL: begin
                                // Column 0 is a hard stop; nothing is erased.
                                if (col_r != '0) begin
                                    col_s     = col_r - 1'b1;
                                    wr_en_s   = 1'b1;
                                    wr_addr_s = {row_r, col_s};
                                    wr_data_s = CHAR_SPACE;
                                end else begin
                                    col_s = col_r;
                                end
                            end
                            CHAR_CR: begin
                                col_s = '0;
                            end
                            CHAR_LF: begin
                                newline_s = 1'b1;
                            end
                            CHAR_FF: begin
                                state_s = ST_CLEAR;
                                sweep_s = '0;
                                row_s   = '0;
                                col_s   = '0;
                            end
                            default: begin
                                consume_s = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    consume_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_CLEAR;
                sweep_s = '0;
                row_s   = '0;
                col_s   = '0;
            end
        endcase

        // Line advance shared by line feed and auto-wrap at the last column.
        if (newline_s) begin
            col_s = '0;
            if (row_r != LAST_ROW) begin
                row_s = row_r + 1'b1;
            end else if (WRAP_MODE == 1) begin
                row_s = '0;
            end else begin
                row_s   = row_r;
                state_s = ST_SCROLL;
                sweep_s = '0;
            end
        end else begin
            newline_s = 1'b0;
        end
    end

    // Controller state, cursor, busy flag and registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_CLEAR;
            sweep_r    <= '0;
            row_r      <= '0;
            col_r      <= '0;
            busy_r     <= 1'b1;
            out_byte_r <= CHAR_SPACE;
        end else begin
            state_r    <= state_s;
            sweep_r    <= sweep_s;
            row_r      <= row_s;
            col_r      <= col_s;
            busy_r     <= (state_s != ST_IDLE);
            out_byte_r <= mem_r[{outRow, outCol}];
        end
    end

    // Character storage; contents are established by the post-reset clear.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= wr_data_s;
        end
    end

    assign outByte   = out_byte_r;
    assign cursorRow = row_r;
    assign cursorCol = col_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_text_screen_buffer.sv
// Self-checking bench for text_screen_buffer (ROWS=4, COLS=16).
// Two instances run side by side on the same byte stream, one scrolling
// and one wrapping, each compared against a behavioural screen model.
module tb_text_screen_buffer;

    localparam int ROWS  = 4;
    localparam int COLS  = 16;
    localparam int NCELL = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       byte_ready;
    logic [7:0] data;
    logic [1:0] out_row;
    logic [3:0] out_col;

    logic [7:0] ob [2];
    logic [1:0] cr [2];
    logic [3:0] cc [2];
    logic       bz [2];
    logic       ov [2];

    always #5 clk = ~clk;

    text_screen_buffer #(.ROWS(ROWS), .COLS(COLS), .WRAP_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .byteReady(byte_ready), .data(data),
        .outRow(out_row), .outCol(out_col), .outByte(ob[0]),
        .cursorRow(cr[0]), .cursorCol(cc[0]), .busy(bz[0]), .overflow(ov[0])
    );

    text_screen_buffer #(.ROWS(ROWS), .COLS(COLS), .WRAP_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .byteReady(byte_ready), .data(data),
        .outRow(out_row), .outCol(out_col), .outByte(ob[1]),
        .cursorRow(cr[1]), .cursorCol(cc[1]), .busy(bz[1]), .overflow(ov[1])
    );

    // Reference model state, index 0 = scrolling, 1 = wrapping.
    logic [7:0] scr [2][NCELL];
    int         m_row [2];
    int         m_col [2];
    int         m_drops [2];

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_seen0 = 0;
    int ovf_seen1 = 0;

    // Count overflow pulses seen on each instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ov[0] === 1'b1) ovf_seen0 = ovf_seen0 + 1;
        if (rst_n === 1'b1 && ov[1] === 1'b1) ovf_seen1 = ovf_seen1 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_newline(int m);
        int b = 0;
        m_col[m] = 0;
        if (m_row[m] < ROWS - 1) begin
            m_row[m] = m_row[m] + 1;
        end else if (m == 1) begin
            m_row[m] = 0;
        end else begin
            for (int i = 0; i < NCELL; i++) begin
                if (i < NCELL - COLS) scr[m][i] = scr[m][i + COLS];
                else                  scr[m][i] = 8'h20;
            end
            b = NCELL;
        end
        return b;
    endfunction

    // Apply one consumed byte to the model; returns expected busy cycles.
    function automatic int model_byte(int m, logic [7:0] d);
        int b = 0;
        if (d >= 8'h20 && d <= 8'h7E) begin
            scr[m][m_row[m] * COLS + m_col[m]] = d;
            if (m_col[m] == COLS - 1) b = model_newline(m);
            else                      m_col[m] = m_col[m] + 1;
        end else if (d == 8'h08 || d == 8'h7F) begin
            if (m_col[m] > 0) begin
                m_col[m] = m_col[m] - 1;
                scr[m][m_row[m] * COLS + m_col[m]] = 8'h20;
            end
        end else if (d == 8'h0D) begin
            m_col[m] = 0;
        end else if (d == 8'h0A) begin
            b = model_newline(m);
        end else if (d == 8'h0C) begin
            for (int i = 0; i < NCELL; i++) scr[m][i] = 8'h20;
            m_row[m] = 0;
            m_col[m] = 0;
            b = NCELL;
        end
        return b;
    endfunction

    // Present one byte as a rising byteReady level; called at a negedge.
    task automatic pulse(input logic [7:0] d);
        byte_ready = 1'b1;
        data       = d;
        @(negedge clk);
        byte_ready = 1'b0;
        @(negedge clk);
    endtask

    // Count busy cycles of each instance until both are idle, then allow
    // any held byte to be consumed.
    task automatic settle(output int c0, output int c1);
        int guard = 0;
        c0 = 0;
        c1 = 0;
        while ((bz[0] === 1'b1 || bz[1] === 1'b1) && guard < 300) begin
            if (bz[0] === 1'b1) c0++;
            if (bz[1] === 1'b1) c1++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 300) check_eq("busy_timeout", 32'(guard), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_cursors(input string tag);
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("%s_m%0d_row", tag, m), 32'(cr[m]), 32'(m_row[m]));
            check_eq($sformatf("%s_m%0d_col", tag, m), 32'(cc[m]), 32'(m_col[m]));
        end
    endtask

    task automatic send_check(input logic [7:0] d, input string tag);
        int b0, b1, c0, c1;
        b0 = model_byte(0, d);
        b1 = model_byte(1, d);
        pulse(d);
        settle(c0, c1);
        check_eq($sformatf("%s_m0_busy", tag), 32'(c0), 32'(b0));
        check_eq($sformatf("%s_m1_busy", tag), 32'(c1), 32'(b1));
        check_cursors(tag);
    endtask

    task automatic read_cell(input int r, input int c);
        out_row = 2'(r);
        out_col = 4'(c);
        @(negedge clk);
    endtask

    task automatic check_screen(input string tag);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_cell(r, c);
                for (int m = 0; m < 2; m++)
                    check_eq($sformatf("%s_m%0d_cell_r%0dc%0d", tag, m, r, c),
                             32'(ob[m]), 32'(scr[m][r * COLS + c]));
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, b0, b1, sel;
        logic [7:0] d;

        rst_n      = 1'b0;
        byte_ready = 1'b1;
        data       = 8'h5A;
        out_row    = 2'd0;
        out_col    = 4'd0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NCELL; i++) scr[m][i] = 8'h20;
            m_row[m]   = 0;
            m_col[m]   = 0;
            m_drops[m] = 0;
        end

        // Reset values, byteReady held high throughout.
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("rst_m%0d_busy", m), 32'(bz[m]), 32'd1);
            check_eq($sformatf("rst_m%0d_outbyte", m), 32'(ob[m]), 32'h20);
            check_eq($sformatf("rst_m%0d_ovf", m), 32'(ov[m]), 32'd0);
        end
        check_cursors("rst");

        rst_n = 1'b1;
        settle(c0, c1);
        check_eq("rst_clear_m0_busy", 32'(c0), 32'd64);
        check_eq("rst_clear_m1_busy", 32'(c1), 32'd64);
        byte_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_cursors("held_level");
        check_screen("after_reset");

        // Backspace over "AB" and past column 0.
        send_check(8'h41, "A");
        send_check(8'h42, "B");
        send_check(8'h08, "bs1");
        read_cell(0, 0);
        check_eq("bs_cell00", 32'(ob[0]), 32'h41);
        read_cell(0, 1);
        check_eq("bs_cell01", 32'(ob[0]), 32'h20);
        check_eq("bs_col_after1", 32'(cc[0]), 32'd1);
        send_check(8'h08, "bs2");
        send_check(8'h7F, "bs3");
        check_eq("bs_col_floor", 32'(cc[0]), 32'd0);

        // Fill four rows then line feed on the last row.
        send_check(8'h0C, "ff_pre_fill");
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS - 1; k++) send_check(8'h61 + 8'(r), "fill");
            if (r < ROWS - 1) send_check(8'h0A, "fill_lf");
        end
        b0 = model_byte(0, 8'h0A);
        b1 = model_byte(1, 8'h0A);
        pulse(8'h0A);
        settle(c0, c1);
        check_eq("scroll_m0_busy", 32'(c0), 32'd64);
        check_eq("wrap_m1_busy", 32'(c1), 32'd0);
        check_eq("scroll_m0_row", 32'(cr[0]), 32'd3);
        check_eq("wrap_m1_row", 32'(cr[1]), 32'd0);
        check_cursors("last_lf");
        read_cell(0, 0);
        check_eq("scroll_m0_row0", 32'(ob[0]), 32'h62);
        check_eq("wrap_m1_row0", 32'(ob[1]), 32'h61);
        check_screen("after_scroll");

        // Two bytes while the scrolling instance is busy.
        b0 = model_byte(0, 8'h0A);
        b1 = model_byte(1, 8'h0A);
        pulse(8'h0A);
        b0 = model_byte(0, 8'h58);
        b1 = model_byte(1, 8'h58);
        pulse(8'h58);
        m_drops[0]++;
        b1 = model_byte(1, 8'h59);
        pulse(8'h59);
        settle(c0, c1);
        check_cursors("ovf");
        check_eq("ovf_m0_count", 32'(ovf_seen0), 32'(m_drops[0]));
        check_eq("ovf_m1_count", 32'(ovf_seen1), 32'(m_drops[1]));
        check_screen("after_ovf");

        // Form feed mid-text, then an ignored control code.
        send_check(8'h48, "H");
        send_check(8'h69, "i");
        b0 = model_byte(0, 8'h0C);
        b1 = model_byte(1, 8'h0C);
        pulse(8'h0C);
        settle(c0, c1);
        check_eq("ff_m0_busy", 32'(c0), 32'd64);
        check_eq("ff_m1_busy", 32'(c1), 32'd64);
        check_eq("ff_m0_col", 32'(cc[0]), 32'd0);
        send_check(8'h07, "bel");
        check_screen("after_ff");

        // Random byte stream.
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 60)      d = 8'($urandom_range(32, 126));
            else if (sel < 70) d = 8'h0A;
            else if (sel < 78) d = 8'h08;
            else if (sel < 82) d = 8'h7F;
            else if (sel < 86) d = 8'h0D;
            else if (sel < 88) d = 8'h0C;
            else if (sel < 94) d = 8'($urandom_range(128, 255));
            else               d = 8'($urandom_range(0, 7));
            send_check(d, "rand");
            if (n % 8 == 7) check_screen("rand_scr");
        end
        check_screen("final");
        check_eq("final_ovf_m0", 32'(ovf_seen0), 32'(m_drops[0]));
        check_eq("final_ovf_m1", 32'(ovf_seen1), 32'(m_drops[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
